// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the 6x6 star-search frame RAM.
// Used by both the frame writer and the readers so the mapping stays identical.
package frame_pkg;

   localparam int X_SZ    = 3;
   localparam int Y_SZ    = 3;
   localparam int ADDR_SZ = 6;
   localparam int COL_SZ  = 3;
   localparam int WIDTH   = 6;
   localparam int HEIGHT  = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } frameState_t;

   function automatic logic isLastPixel(input logic [X_SZ-1:0] x, input logic [Y_SZ-1:0] y);
      return (x == X_SZ'(WIDTH - 1)) && (y == Y_SZ'(HEIGHT - 1));
   endfunction

endpackage

// File: rtl/pixel_frame_writer_if.sv
// Stream-in / RAM-write-out bundle of the frame writer.
// master drives the request and pixel stream; slave is the writer itself.
interface pixel_frame_writer_if;
   import frame_pkg::*;

   logic                start;
   logic                clearReq;
   logic [COL_SZ-1:0]   pixIn;
   logic                pixValid;
   logic                pixReady;
   logic [ADDR_SZ-1:0]  memAddress;
   logic [COL_SZ-1:0]   memData;
   logic                memWren;
   logic [X_SZ-1:0]     xCount;
   logic [Y_SZ-1:0]     yCount;
   logic                busy;
   logic                frameDone;

   modport master (
      output start, clearReq, pixIn, pixValid,
      input  pixReady, memAddress, memData, memWren, xCount, yCount, busy, frameDone
   );

   modport slave (
      input  start, clearReq, pixIn, pixValid,
      output pixReady, memAddress, memData, memWren, xCount, yCount, busy, frameDone
   );

endinterface

// File: rtl/address_translator.sv
// Raster (x,y) to frame RAM address: y*WIDTH + x, with WIDTH=6 built from shifts.
// Shared by the frame writer and the star-search readers.
module address_translator
   import frame_pkg::*;
(
   input  logic [X_SZ-1:0]    x,
   input  logic [Y_SZ-1:0]    y,
   output logic [ADDR_SZ-1:0] memAddress
);

   logic [ADDR_SZ-1:0] xExt;
   logic [ADDR_SZ-1:0] yExt;

   assign xExt       = ADDR_SZ'(x);
   assign yExt       = ADDR_SZ'(y);
   assign memAddress = (yExt << 2) + (yExt << 1) + xExt;

endmodule

// File: rtl/pixel_frame_writer.sv
// Fills the 36-word pixel RAM from a raster-order valid/ready stream or with a
// constant colour; the write port is registered, one cycle behind the counters.
module pixel_frame_writer
   import frame_pkg::*;
#(
   parameter logic [COL_SZ-1:0] FILL_COLOUR = '0
) (
   input  logic clk,
   input  logic resetn,
   pixel_frame_writer_if.slave bus
);

   frameState_t        state;
   frameState_t        nextState;
   logic [X_SZ-1:0]    xCount;
   logic [Y_SZ-1:0]    yCount;
   logic [ADDR_SZ-1:0] pixAddress;
   logic [ADDR_SZ-1:0] memAddress;
   logic [COL_SZ-1:0]  memData;
   logic               memWren;
   logic               pixReady;
   logic               busy;
   logic               frameDone;
   logic               advance;
   logic               lastPixel;

   address_translator addrMap (
      .x          (xCount),
      .y          (yCount),
      .memAddress (pixAddress)
   );

   // NOTE: registers update with non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= nextState;
   end

   // NOTE: each combinational output gets a default first so no path can infer a latch.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:  if (bus.start) nextState = bus.clearReq ? CLEAR : LOAD;
         CLEAR: if (lastPixel) nextState = DONE;
         LOAD:  if (lastPixel) nextState = DONE;
         DONE:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      pixReady  = (state == LOAD);
      busy      = (state == CLEAR) || (state == LOAD);
      frameDone = (state == DONE);
      advance   = (state == CLEAR) || (pixReady && bus.pixValid);
      lastPixel = advance && isLastPixel(xCount, yCount);
   end

   // Counters only move on a write; outside CLEAR/LOAD they sit at the origin.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         xCount <= '0;
         yCount <= '0;
      end else if (!busy) begin
         xCount <= '0;
         yCount <= '0;
      end else if (advance) begin
         if (xCount == X_SZ'(WIDTH - 1)) begin
            xCount <= '0;
            yCount <= (yCount == Y_SZ'(HEIGHT - 1)) ? '0 : yCount + Y_SZ'(1);
         end else begin
            xCount <= xCount + X_SZ'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         memAddress <= '0;
         memData    <= '0;
         memWren    <= 1'b0;
      end else begin
         memWren <= advance;
         if (advance) begin
            memAddress <= pixAddress;
            memData    <= (state == CLEAR) ? FILL_COLOUR : bus.pixIn;
         end
      end
   end

   assign bus.pixReady   = pixReady;
   assign bus.busy       = busy;
   assign bus.frameDone  = frameDone;
   assign bus.memAddress = memAddress;
   assign bus.memData    = memData;
   assign bus.memWren    = memWren;
   assign bus.xCount     = xCount;
   assign bus.yCount     = yCount;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Scoreboard bench for pixel_frame_writer: the driver predicts each RAM write from
// raster-order pixel indices, a monitor compares every observed write.
module tb_pixel_frame_writer;
   import frame_pkg::*;

   localparam int NPIX = WIDTH * HEIGHT;
   localparam logic [COL_SZ-1:0] FILL = '0;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   pixel_frame_writer_if bus();

   pixel_frame_writer #(.FILL_COLOUR(FILL)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
   } wrExp_t;

   wrExp_t expQ[$];
   int     checks     = 0;
   int     failures   = 0;
   int     doneCount  = 0;
   int     writeCount = 0;
   int     tbRam[NPIX];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: every RAM write must match the oldest predicted write.
   initial begin
      wrExp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (resetn) begin
            if (bus.memWren === 1'b1) begin
               writeCount++;
               if (expQ.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpectedWrite: got addr %0d data %0d expected no write", bus.memAddress, bus.memData);
               end else begin
                  e = expQ.pop_front();
                  check("writeAddr", 32'(bus.memAddress), e.addr);
                  check("writeData", 32'(bus.memData), e.data);
                  check("frameDoneOnWrite", 32'(bus.frameDone), 32'(e.addr == NPIX - 1));
                  if (int'(bus.memAddress) < NPIX) tbRam[bus.memAddress] = int'(bus.memData);
               end
            end else begin
               check("frameDoneWithoutWrite", 32'(bus.frameDone), 0);
            end
            if (bus.frameDone === 1'b1) doneCount++;
         end
      end
   end

   // mode 0: valid held, data = index mod 8; mode 1: valid toggles; mode 2: random valid/data
   task automatic runLoad(input int mode, input bit midStart, input int stopAfter);
      int count = 0;
      int cyc   = 0;
      bit valid;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.clearReq = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      while (count < stopAfter && cyc < 1000) begin
         case (mode)
            0:       valid = 1'b1;
            1:       valid = (cyc % 2 == 0);
            default: valid = 1'($urandom_range(0, 1));
         endcase
         bus.pixValid = valid;
         bus.pixIn    = (mode == 0) ? COL_SZ'(count % 8) : COL_SZ'($urandom_range(0, 7));
         if (midStart && cyc == 3) begin
            bus.start    = 1'b1;
            bus.clearReq = 1'b1;
         end
         check("loadReady", 32'(bus.pixReady), 1);
         check("loadBusy", 32'(bus.busy), 1);
         check("loadX", 32'(bus.xCount), count % WIDTH);
         check("loadY", 32'(bus.yCount), count / WIDTH);
         if (valid) begin
            expQ.push_back('{addr: count, data: int'(bus.pixIn)});
            count++;
         end
         cyc++;
         @(negedge clk);
      end
      check("loadAcceptsWithinBudget", 32'(count), stopAfter);
      if (stopAfter == NPIX) begin
         bus.pixValid = 1'b1;
         bus.pixIn    = COL_SZ'($urandom_range(0, 7));
         check("doneReady", 32'(bus.pixReady), 0);
         check("doneBusy", 32'(bus.busy), 0);
         check("doneFrameDone", 32'(bus.frameDone), 1);
         check("doneX", 32'(bus.xCount), 0);
         check("doneY", 32'(bus.yCount), 0);
         @(negedge clk);
         check("idleReady", 32'(bus.pixReady), 0);
         check("idleFrameDone", 32'(bus.frameDone), 0);
         bus.pixValid = 1'b0;
      end
   endtask

   // Entered on the first negedge of CLEAR.
   task automatic clearBody();
      for (int i = 0; i < NPIX; i++) expQ.push_back('{addr: i, data: int'(FILL)});
      for (int i = 0; i < NPIX; i++) begin
         bus.pixValid = 1'($urandom_range(0, 1));
         check($sformatf("clearBusy%0d", i), 32'(bus.busy), 1);
         check("clearReady", 32'(bus.pixReady), 0);
         @(negedge clk);
      end
      check("clearDoneBusy", 32'(bus.busy), 0);
      check("clearFrameDone", 32'(bus.frameDone), 1);
      @(negedge clk);
      check("clearIdleFrameDone", 32'(bus.frameDone), 0);
      check("clearIdleBusy", 32'(bus.busy), 0);
      bus.pixValid = 1'b0;
      for (int i = 0; i < NPIX; i++) check($sformatf("ramAfterClear%0d", i), tbRam[i], int'(FILL));
   endtask

   task automatic runClear();
      @(negedge clk);
      bus.start    = 1'b1;
      bus.clearReq = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.clearReq = 1'b0;
      clearBody();
   endtask

   // Called on a LOAD negedge; reset lands mid-cycle, away from both edges.
   task automatic pulseReset();
      check("preResetReady", 32'(bus.pixReady), 1);
      #2;
      resetn       = 1'b0;
      bus.pixValid = 1'b0;
      bus.start    = 1'b0;
      #1;
      check("rstWren", 32'(bus.memWren), 0);
      check("rstReady", 32'(bus.pixReady), 0);
      check("rstBusy", 32'(bus.busy), 0);
      check("rstFrameDone", 32'(bus.frameDone), 0);
      check("rstX", 32'(bus.xCount), 0);
      check("rstY", 32'(bus.yCount), 0);
      expQ.delete();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic checkFrameTotals(input string name, input int done0, input int wr0, input int frames);
      check({name, "Done"}, doneCount - done0, frames);
      check({name, "Writes"}, writeCount - wr0, frames * NPIX);
   endtask

   initial begin
      int done0;
      int wr0;
      bus.start    = 1'b0;
      bus.clearReq = 1'b0;
      bus.pixIn    = '0;
      bus.pixValid = 1'b0;
      for (int i = 0; i < NPIX; i++) tbRam[i] = -1;

      #12;
      check("resetAddr", 32'(bus.memAddress), 0);
      check("resetData", 32'(bus.memData), 0);
      check("resetWren", 32'(bus.memWren), 0);
      check("resetReady", 32'(bus.pixReady), 0);
      check("resetBusy", 32'(bus.busy), 0);
      check("resetFrameDone", 32'(bus.frameDone), 0);
      check("resetX", 32'(bus.xCount), 0);
      check("resetY", 32'(bus.yCount), 0);
      @(negedge clk);
      resetn = 1'b1;

      done0 = doneCount; wr0 = writeCount;
      runLoad(0, 1'b0, NPIX);
      checkFrameTotals("loadHeld", done0, wr0, 1);
      for (int i = 0; i < NPIX; i++) check($sformatf("ramAfterLoad%0d", i), tbRam[i], i % 8);

      done0 = doneCount; wr0 = writeCount;
      runClear();
      checkFrameTotals("clear", done0, wr0, 1);

      done0 = doneCount; wr0 = writeCount;
      runLoad(1, 1'b0, NPIX);
      checkFrameTotals("loadToggle", done0, wr0, 1);

      runLoad(0, 1'b0, 7);
      check("rowWrapX", 32'(bus.xCount), 1);
      check("rowWrapY", 32'(bus.yCount), 1);
      pulseReset();

      runLoad(2, 1'b0, 10);
      pulseReset();
      done0 = doneCount; wr0 = writeCount;
      runLoad(2, 1'b0, NPIX);
      checkFrameTotals("loadAfterReset", done0, wr0, 1);

      done0 = doneCount; wr0 = writeCount;
      runLoad(2, 1'b1, NPIX);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.clearReq = 1'b0;
      clearBody();
      checkFrameTotals("startDuringLoad", done0, wr0, 2);

      repeat (4) @(negedge clk);
      check("pendingWrites", expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pixel_frame_writer.md
Name: pixel_frame_writer

Overview:
Write-side companion to the star-search datapath. It fills the 36x3 pixel RAM (6x6 frame, 3-bit colour) either from a valid/ready pixel stream in raster order or with a constant fill colour. It drives the RAM write port (address, data, wren); the star-search blocks read the frame only after frameDone.

Parameters:
X_SZ, 3, x coordinate width
Y_SZ, 3, y coordinate width
ADDR_SZ, 6, RAM address width
COL_SZ, 3, pixel colour width
WIDTH, 6, frame width in pixels
HEIGHT, 6, frame height in pixels
FILL_COLOUR, 0, value written in clear mode

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  begin a frame operation; sampled only in IDLE
clearReq  in  1  sampled with start: 1 = clear mode, 0 = load mode
pixIn  in  COL_SZ  stream pixel colour
pixValid  in  1  pixIn valid
pixReady  out  1  writer accepts pixel this cycle
memAddress  out  ADDR_SZ  RAM write address
memData  out  COL_SZ  RAM write data
memWren  out  1  RAM write enable
xCount  out  X_SZ  current x of next write
yCount  out  Y_SZ  current y of next write
busy  out  1  high in CLEAR or LOAD
frameDone  out  1  one-cycle pulse when the last pixel is written

Behaviour:
- Reset (async, resetn=0): state IDLE; xCount=0, yCount=0, memAddress=0, memData=0, memWren=0, pixReady=0, busy=0, frameDone=0. Reset mid-frame abandons the frame with no further writes. Already-written RAM words are not restored.
- States: IDLE, CLEAR, LOAD, DONE.
- IDLE: counters held at 0.
  - start=1 and clearReq=1 -> CLEAR.
  - start=1 and clearReq=0 -> LOAD.
  - start=0 -> stay.
- CLEAR: one write per cycle. memData=FILL_COLOUR and memWren=1 are registered, issued the cycle after each counter value. 36 consecutive writes, addresses 0..35. After the write for (5,5) is issued -> DONE.
- LOAD: pixReady=1 combinationally in LOAD only.
  - Accept occurs when pixValid && pixReady.
  - On accept: register memAddress=addr(xCount,yCount), memData=pixIn, memWren=1 (1-cycle latency), then advance the counters.
  - No accept: memWren=0 next cycle; counters hold (stall); no write is issued.
  - Accepting (5,5) -> DONE. pixReady drops in DONE, so no pixel beyond the 36th is consumed.
- Counter advance:
  - x<WIDTH-1: x+1.
  - x=WIDTH-1: x->0, y+1.
  - x=WIDTH-1 and y=HEIGHT-1: the last pixel. Counters wrap to 0,0 and the state moves to DONE.
- DONE: lasts exactly one cycle. The final write (memWren=1) is visible this cycle; frameDone=1 in the same cycle. Next state is IDLE, with frameDone=0 and memWren=0.
- Address arithmetic: addr = y*4 + y*2 + x, zero-extended operands, unsigned. Range 0..35; values 36..63 are never produced.
- busy = (state==CLEAR || state==LOAD).
- start is ignored while busy or in DONE. A start held high through DONE begins a new operation on the first IDLE cycle.
- pixValid outside LOAD is ignored; pixReady=0.
- clearReq is sampled only with start in IDLE; later changes have no effect.

Decomposition:
- Shared package frame_pkg:
  - constants X_SZ, Y_SZ, ADDR_SZ, COL_SZ, WIDTH, HEIGHT.
  - state encoding: IDLE=2'd0, CLEAR=2'd1, LOAD=2'd2, DONE=2'd3.
- Sub-module: reuse the existing address_translator (x,y -> mem_address) for address generation, so reader and writer share one mapping.
- FSM and counters stay in pixel_frame_writer; no separate control/datapath split is required.

Test Plan:
- Load, pixValid held 1, pixIn = (addr mod 8) -> exactly 36 writes, addresses 0..35 in order, data matches; frameDone one pulse coinciding with the write to addr 35; pixReady=0 afterwards.
- Clear with FILL_COLOUR=0 -> 36 consecutive cycles of memWren=1 with data 0, addr 0..35; busy=1 for 36 cycles; frameDone once; RAM model reads all 0.
- Load with pixValid toggling 1,0,1,0 -> writes only on accept cycles; counters hold during gaps; pixel 7 lands at addr 7 (x=1,y=1); total 36 writes.
- Row wrap: accept 6 pixels -> write addresses 0..5, then xCount=0, yCount=1, next write at addr 6.
- resetn pulsed low after 10 accepts, asynchronously mid-cycle -> memWren=0 and pixReady=0 immediately; state IDLE; counters 0; a subsequent load restarts at addr 0.
- start asserted during LOAD with clearReq=1 -> ignored, no CLEAR writes; after frameDone, a held start triggers CLEAR in the next IDLE cycle.
